rcb_frl_train_aligner: RTL and testbench
========================================

Name: rcb_frl_train_aligner

Overview:
- RX-side word-alignment stage of the fast radio link. It sits directly downstream of the 8-bit deserializer and upstream of the frame decoder.
- It watches deserialized bytes for the training pattern and pulses bitslip to the ISERDES until the pattern is found.
- It then counts consecutive matches through a 4-bit 0..15 match counter and declares lock after 16 consecutive matches.
- The aligned flag gates the downstream frame decoder.

Parameters:
- TRAIN_PATTERN, 8'hF4, training byte expected during link training.
- SLIP_WAIT, 4, clk cycles to wait after each bitslip pulse before sampling again (ISERDES settle time); legal range 1..15.
- MAX_SLIPS, 8, bitslips attempted without success before align_fail is raised; legal range 1..15.

Ports:
- clk  input  1  fabric clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- data_in  input  8  deserialized byte.
- data_valid  input  1  data_in qualifier; words with data_valid=0 are ignored.
- retrain  input  1  single-cycle request to drop lock and restart the search.
- bitslip  output  1  one-cycle pulse to the ISERDES BITSLIP pin.
- aligned  output  1  high while in LOCKED.
- align_fail  output  1  sticky; set when MAX_SLIPS is exhausted.
- match_count  output  4  current consecutive-match count.
- slip_count  output  4  bitslips issued since the last search start.

Behaviour:
- Reset (rst_n=0, asynchronous): state=SEARCH; bitslip=0, aligned=0, align_fail=0, match_count=0, slip_count=0; wait counter=0. All outputs are registered.
- States: SEARCH, SLIP_WAIT, VERIFY, LOCKED.
- SEARCH, on a valid word:
  - Match (data_in==TRAIN_PATTERN): match_count<=1, go to VERIFY.
  - Mismatch and slip_count<MAX_SLIPS: bitslip<=1 for exactly one cycle, slip_count++, wait counter loaded with SLIP_WAIT, go to SLIP_WAIT.
  - Mismatch and slip_count==MAX_SLIPS: align_fail<=1, slip_count<=0, bitslip<=1, go to SLIP_WAIT. The search keeps cycling; align_fail stays high.
- SLIP_WAIT: data is ignored. The wait counter decrements every clk regardless of data_valid. Go to SEARCH on the cycle the counter reaches 0. bitslip is never asserted in this state beyond the first cycle.
- VERIFY, on a valid word:
  - Match with match_count<15: match_count++.
  - Match with match_count==15 (the 16th consecutive match): go to LOCKED; aligned<=1 on the next edge; match_count held at 15.
  - Mismatch: match_count<=0, return to SEARCH. No slip is issued, and the next valid word is re-examined in SEARCH.
- VERIFY, no valid word: hold state and counts.
- LOCKED: aligned=1; data is not checked (payload follows training); match_count holds at 15; slip_count holds its final value.
- retrain=1, any state: next state SEARCH; aligned, match_count, slip_count and bitslip all cleared. align_fail is not cleared; only rst_n clears it. retrain takes priority over every other transition in the same cycle.
- Lock latency: aligned rises on the clk edge following the sample of the 16th consecutive matching valid word.
- Counter arithmetic is unsigned:
  - The match counter never wraps; it saturates at 15 in VERIFY/LOCKED.
  - slip_count is bounded by MAX_SLIPS and reset on wrap.
- rst_n asserted mid-slip: bitslip drops immediately (asynchronous).

Decomposition:
- Shared FRL package holds:
  - state encoding constants (SEARCH=2'd0, SLIP_WAIT=2'd1, VERIFY=2'd2, LOCKED=2'd3);
  - the default TRAIN_PATTERN constant;
  - the lock-length constant (16).
- One sub-module, rcb_frl_match_counter: 4-bit counter with asynchronous active-low reset, synchronous clear and increment-enable, saturating at 15. It is instantiated for match_count; the slip counter and wait counter stay inline.

Test Plan:
- Clean lock: rst_n released, data_valid=1, 16 bytes of 8'hF4 -> bitslip never pulses; match_count steps 1..15; aligned=1 on the edge after the 16th byte; slip_count=0.
- Misaligned start: 3 bytes of 8'h7A, then 8'hF4 forever -> 3 single-cycle bitslip pulses, each followed by exactly 4 dead cycles; slip_count=3; aligned after 16 matches.
- Broken run: 10×8'hF4, one 8'h00, 16×8'hF4 -> match_count returns to 0 after the 8'h00, no bitslip; aligned only after the second run; match_count=15 while LOCKED.
- Exhaustion: constant 8'h00 -> after 8 slips the 9th mismatch sets align_fail=1 and slip_count wraps to 0; bitslip keeps pulsing every 5 cycles; a later F4 run still locks with align_fail remaining 1.
- Retrain and reset: in LOCKED pulse retrain -> aligned=0, match_count=0 next cycle, state SEARCH. Assert rst_n=0 mid-SLIP_WAIT -> all outputs, including align_fail, read 0 immediately.
- Valid gaps: 16 matching bytes interleaved with data_valid=0 cycles -> lock still achieved; match_count unchanged on invalid cycles.

Source files
------------

// File: rtl/rcb_frl_train_aligner_pkg.sv
// Shared constants for the fast radio link word-alignment stage.
package rcb_frl_train_aligner_pkg;

  // Aligner FSM state encoding
  typedef enum logic [1:0] {
    StSearch   = 2'd0,
    StSlipWait = 2'd1,
    StVerify   = 2'd2,
    StLocked   = 2'd3
  } frl_state_e;

  // Default training byte sent by the far end during link training
  localparam logic [7:0] FRL_TRAIN_PATTERN = 8'hF4;

  // Consecutive matches required before lock is declared
  localparam int unsigned FRL_LOCK_LEN = 16;

  // Terminal value of the 4-bit match counter
  localparam logic [3:0] FRL_MATCH_MAX = 4'(FRL_LOCK_LEN - 1);

endpackage

// File: rtl/rcb_frl_match_counter.sv
// 4-bit saturating counter with synchronous clear and increment enable.
module rcb_frl_match_counter (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_clr,
  input  logic       i_inc,
  output logic [3:0] o_count
);

  logic [3:0] r_count;

  // Clear wins over increment; increment stops at 15 instead of wrapping
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= 4'd0;
    end else if (i_clr) begin
      r_count <= 4'd0;
    end else if (i_inc && (r_count != 4'hF)) begin
      r_count <= r_count + 4'd1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/rcb_frl_train_aligner.sv
// RX word aligner: bitslips the deserializer until the training byte is seen, then
// requires a run of consecutive matches before raising aligned.
module rcb_frl_train_aligner
  import rcb_frl_train_aligner_pkg::*;
#(
  parameter logic [7:0]  TRAIN_PATTERN = FRL_TRAIN_PATTERN,
  parameter int unsigned SLIP_WAIT     = 4,
  parameter int unsigned MAX_SLIPS     = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_data_in,
  input  logic       i_data_valid,
  input  logic       i_retrain,
  output logic       o_bitslip,
  output logic       o_aligned,
  output logic       o_align_fail,
  output logic [3:0] o_match_count,
  output logic [3:0] o_slip_count
);

  localparam logic [3:0] SlipWaitLd = 4'(SLIP_WAIT);
  localparam logic [3:0] MaxSlipsW  = 4'(MAX_SLIPS);

  frl_state_e r_state, w_state_d;
  logic [3:0] r_slip,  w_slip_d;
  logic [3:0] r_wait,  w_wait_d;
  logic       r_bitslip, w_bitslip_d;
  logic       r_aligned, w_aligned_d;
  logic       r_fail,    w_fail_d;
  logic       w_match_clr, w_match_inc;
  logic       w_match;
  logic [3:0] w_match_count;

  assign w_match = (i_data_in == TRAIN_PATTERN);

  rcb_frl_match_counter u_match_counter (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_match_clr),
    .i_inc   (w_match_inc),
    .o_count (w_match_count)
  );

  // State and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= StSearch;
      r_slip    <= 4'd0;
      r_wait    <= 4'd0;
      r_bitslip <= 1'b0;
      r_aligned <= 1'b0;
      r_fail    <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_slip    <= w_slip_d;
      r_wait    <= w_wait_d;
      r_bitslip <= w_bitslip_d;
      r_aligned <= w_aligned_d;
      r_fail    <= w_fail_d;
    end
  end

  // Next-state logic; retrain overrides every other transition
  always_comb begin
    w_state_d   = r_state;
    w_slip_d    = r_slip;
    w_wait_d    = r_wait;
    w_bitslip_d = 1'b0;
    w_aligned_d = r_aligned;
    w_fail_d    = r_fail;
    w_match_clr = 1'b0;
    w_match_inc = 1'b0;

    if (i_retrain) begin
      w_state_d   = StSearch;
      w_slip_d    = 4'd0;
      w_wait_d    = 4'd0;
      w_aligned_d = 1'b0;
      w_match_clr = 1'b1;
    end else begin
      unique case (r_state)
        StSearch: begin
          if (i_data_valid) begin
            if (w_match) begin
              // Match counter is always 0 here, so this yields 1
              w_match_inc = 1'b1;
              w_state_d   = StVerify;
            end else begin
              w_bitslip_d = 1'b1;
              w_wait_d    = SlipWaitLd;
              w_state_d   = StSlipWait;
              if (r_slip >= MaxSlipsW) begin
                // Out of slips: flag it, then keep hunting from slip 0
                w_fail_d = 1'b1;
                w_slip_d = 4'd0;
              end else begin
                w_slip_d = r_slip + 4'd1;
              end
            end
          end
        end
        StSlipWait: begin
          // Counts every clock, valid or not, to cover ISERDES settle time
          if (r_wait != 4'd0) begin
            w_wait_d = r_wait - 4'd1;
          end
          if (r_wait <= 4'd1) begin
            w_state_d = StSearch;
          end
        end
        StVerify: begin
          if (i_data_valid) begin
            if (!w_match) begin
              w_match_clr = 1'b1;
              w_state_d   = StSearch;
            end else if (w_match_count == FRL_MATCH_MAX) begin
              w_state_d   = StLocked;
              w_aligned_d = 1'b1;
            end else begin
              w_match_inc = 1'b1;
            end
          end
        end
        StLocked: begin
          w_aligned_d = 1'b1;
        end
        default: begin
          w_state_d = StSearch;
        end
      endcase
    end
  end

  assign o_bitslip     = r_bitslip;
  assign o_aligned     = r_aligned;
  assign o_align_fail  = r_fail;
  assign o_match_count = w_match_count;
  assign o_slip_count  = r_slip;

endmodule

// File: tb/tb_rcb_frl_train_aligner.sv
// Directed bench for the word aligner: vector table plus hand-written multi-cycle sequences.
module tb_rcb_frl_train_aligner;

  logic       clk;
  logic       rst_n;
  logic [7:0] data_in;
  logic       data_valid;
  logic       retrain;
  logic       bitslip;
  logic       aligned;
  logic       align_fail;
  logic [3:0] match_count;
  logic [3:0] slip_count;

  int total;
  int bad;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       rt;
    logic       bs;
    logic       al;
    logic       af;
    logic [3:0] mc;
    logic [3:0] sc;
  } vec_t;

  vec_t tbl [20];

  rcb_frl_train_aligner #(
    .TRAIN_PATTERN (8'hF4),
    .SLIP_WAIT     (4),
    .MAX_SLIPS     (8)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_data_in     (data_in),
    .i_data_valid  (data_valid),
    .i_retrain     (retrain),
    .o_bitslip     (bitslip),
    .o_aligned     (aligned),
    .o_align_fail  (align_fail),
    .o_match_count (match_count),
    .o_slip_count  (slip_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs at negedge, sample outputs 1 time unit after posedge
  task automatic cyc(input logic v, input logic [7:0] d, input logic rt);
    @(negedge clk);
    data_valid = v;
    data_in    = d;
    retrain    = rt;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    data_valid = 1'b0;
    data_in    = 8'h00;
    retrain    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_all(input string tag, input logic bs, input logic al, input logic af,
                           input logic [3:0] mc, input logic [3:0] sc);
    check({tag, ".bitslip"}, {7'd0, bitslip}, {7'd0, bs});
    check({tag, ".aligned"}, {7'd0, aligned}, {7'd0, al});
    check({tag, ".align_fail"}, {7'd0, align_fail}, {7'd0, af});
    check({tag, ".match_count"}, {4'd0, match_count}, {4'd0, mc});
    check({tag, ".slip_count"}, {4'd0, slip_count}, {4'd0, sc});
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst_n      = 1'b0;
    data_in    = 8'h00;
    data_valid = 1'b0;
    retrain    = 1'b0;

    // Clean lock, then locked payload, retrain, retrain priority, first slip
    for (int i = 0; i < 16; i++) begin
      tbl[i] = '{v: 1'b1, d: 8'hF4, rt: 1'b0, bs: 1'b0, al: (i == 15), af: 1'b0,
                 mc: (i < 15) ? 4'(i + 1) : 4'd15, sc: 4'd0};
    end
    tbl[16] = '{v: 1'b1, d: 8'h00, rt: 1'b0, bs: 1'b0, al: 1'b1, af: 1'b0, mc: 4'd15, sc: 4'd0};
    tbl[17] = '{v: 1'b0, d: 8'h00, rt: 1'b1, bs: 1'b0, al: 1'b0, af: 1'b0, mc: 4'd0, sc: 4'd0};
    tbl[18] = '{v: 1'b1, d: 8'hF4, rt: 1'b1, bs: 1'b0, al: 1'b0, af: 1'b0, mc: 4'd0, sc: 4'd0};
    tbl[19] = '{v: 1'b1, d: 8'h00, rt: 1'b0, bs: 1'b1, al: 1'b0, af: 1'b0, mc: 4'd0, sc: 4'd1};

    do_reset();
    #1;
    check_all("reset", 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    for (int i = 0; i < 20; i++) begin
      cyc(tbl[i].v, tbl[i].d, tbl[i].rt);
      check_all($sformatf("tbl[%0d]", i), tbl[i].bs, tbl[i].al, tbl[i].af, tbl[i].mc, tbl[i].sc);
    end

    // Misaligned start: slips land on edges 1, 6, 11; first F4 sampled on edge 16
    do_reset();
    for (int e = 1; e <= 32; e++) begin
      logic       ebs;
      logic [3:0] esc;
      logic [3:0] emc;
      cyc(1'b1, (e <= 15) ? 8'h7A : 8'hF4, 1'b0);
      ebs = (e == 1) || (e == 6) || (e == 11);
      esc = (e >= 11) ? 4'd3 : (e >= 6) ? 4'd2 : 4'd1;
      emc = (e < 16) ? 4'd0 : (e >= 30) ? 4'd15 : 4'(e - 15);
      check_all($sformatf("misalign.e%0d", e), ebs, (e >= 31), 1'b0, emc, esc);
    end

    // Broken run: 10 matches, one miss, then 16 matches
    do_reset();
    for (int e = 1; e <= 28; e++) begin
      logic [7:0] d;
      logic [3:0] emc;
      d   = (e == 11) ? 8'h00 : 8'hF4;
      emc = (e <= 10) ? 4'(e) : (e == 11) ? 4'd0 : (e >= 26) ? 4'd15 : 4'(e - 11);
      cyc(1'b1, d, 1'b0);
      check_all($sformatf("broken.e%0d", e), 1'b0, (e >= 27), 1'b0, emc, 4'd0);
    end

    // Exhaustion: slips every 5 cycles, the 9th wraps slip_count and sets align_fail
    do_reset();
    for (int e = 1; e <= 50; e++) begin
      int         n;
      logic [3:0] esc;
      cyc(1'b1, 8'h00, 1'b0);
      n   = (e - 1) / 5 + 1;
      esc = (n <= 8) ? 4'(n) : 4'(n - 9);
      check_all($sformatf("exhaust.e%0d", e), ((e % 5) == 1), 1'b0, (n >= 9), 4'd0, esc);
    end
    for (int e = 51; e <= 66; e++) begin
      cyc(1'b1, 8'hF4, 1'b0);
    end
    check_all("exhaust.relock", 1'b0, 1'b1, 1'b1, 4'd15, 4'd1);

    // Retrain keeps align_fail; reset mid-slip clears everything without a clock
    cyc(1'b0, 8'h00, 1'b1);
    check_all("retrain.keepfail", 1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
    cyc(1'b1, 8'h00, 1'b0);
    check_all("slip.before_rst", 1'b1, 1'b0, 1'b1, 4'd0, 4'd1);
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);

    // Valid gaps: invalid cycles carry junk and must not move the counter
    do_reset();
    for (int i = 0; i < 32; i++) begin
      int         nv;
      logic [3:0] emc;
      cyc(((i % 2) == 0), ((i % 2) == 0) ? 8'hF4 : 8'h00, 1'b0);
      nv  = i / 2 + 1;
      emc = (nv > 15) ? 4'd15 : 4'(nv);
      check_all($sformatf("gaps.i%0d", i), 1'b0, (nv >= 16), 1'b0, emc, 4'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
